fifo_frame_packer: RTL and testbench

- Downstream consumer of the sample FIFO: drains 16-bit ADC samples and emits framed packets on a valid/ready stream toward the host/DMA interface.
- Each frame is: sync/sequence header, length word, N payload samples, then a 16-bit checksum word.
- A full burst starts when FIFO occupancy reaches BURST_LEN. A partial frame is flushed after an idle timeout, so low-rate data still drains.

---
 rtl/frame_pkg.sv | 11 +
 rtl/frame_skid_buf.sv | 29 ++
 rtl/fifo_frame_packer.sv | 110 +++++++++++
 tb/tb_fifo_frame_packer.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/frame_pkg.sv
// frame_pkg: shared state type and word helpers for the FIFO frame packer.
package frame_pkg;
    typedef enum logic [2:0] {IDLE, HDR, LEN, PAYLOAD, CSUM} state_t;
    localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
    function automatic logic [15:0] hdr_word(input logic [7:0] sync, input logic [7:0] seq);
        return {sync, seq};
    endfunction
    function automatic logic [15:0] csum_add(input logic [15:0] sum, input logic [15:0] word);
        return sum + word;
    endfunction
endpackage

// File: rtl/frame_skid_buf.sv
// frame_skid_buf: 2-entry buffer catching FIFO read data, popped on stream handshake.
module frame_skid_buf #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         out_ready,
    output logic         out_valid,
    output logic [W-1:0] out_data,
    output logic [1:0]   count
);
    logic [W-1:0] e0, e1;
    logic pop;
    assign out_valid = count != 2'd0;
    assign out_data = e0;
    assign pop = out_valid && out_ready;
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            e0 <= '0;
            e1 <= '0;
            count <= 2'd0;
        end else begin
            e0 <= pop ? (count == 2'd2 || !push ? e1 : push_data) : (count == 2'd0 && push ? push_data : e0);
            e1 <= push && (pop ? count == 2'd2 : count == 2'd1) ? push_data : e1;
            count <= count + 2'(push) - 2'(pop);
        end
endmodule

// File: rtl/fifo_frame_packer.sv
// fifo_frame_packer: drains the sample FIFO into header/length/payload/checksum frames
// on a valid/ready stream; full bursts at BURST_LEN, partial flush after an idle timeout.
module fifo_frame_packer
    import frame_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int CNT_WIDTH = 10,
    parameter int BURST_LEN = 256,
    parameter int TIMEOUT_CYC = 1024,
    parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    output logic                  fifo_rd_en,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data,
    input  logic                  fifo_empty,
    input  logic [CNT_WIDTH-1:0]  fifo_count,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  m_last,
    output logic [7:0]            frame_seq,
    output logic [15:0]           frames_sent,
    output logic                  flush_pulse,
    output logic                  busy
);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_WIDTH-1:0] BURST = CNT_WIDTH'(BURST_LEN);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYC - 1);

    state_t state, state_nx;
    logic [CNT_WIDTH-1:0] frame_len, issued, sent;
    logic [TW-1:0] timer;
    logic [15:0] csum;
    logic inflight, skid_valid, xfer, pop, burst_go, idle_arm, time_go, start;
    logic [DATA_WIDTH-1:0] skid_data;
    logic [1:0] skid_cnt;

    frame_skid_buf #(.W(DATA_WIDTH)) u_skid (
        .clk(clk),
        .rst(rst),
        .push(inflight),
        .push_data(fifo_rd_data),
        .out_ready(m_ready && state == PAYLOAD),
        .out_valid(skid_valid),
        .out_data(skid_data),
        .count(skid_cnt)
    );

    always_comb begin
        burst_go = state == IDLE && enable && fifo_count >= BURST;
        idle_arm = state == IDLE && enable && fifo_count != '0 && !burst_go;
        time_go = idle_arm && timer == T_LAST;
        start = burst_go || time_go;
        m_valid = state == HDR || state == LEN || state == CSUM || (state == PAYLOAD && skid_valid);
        m_last = state == CSUM;
        m_data = state == HDR ? DATA_WIDTH'(hdr_word(SYNC_BYTE, frame_seq)) :
                 state == LEN ? DATA_WIDTH'(frame_len) :
                 state == PAYLOAD ? skid_data :
                 state == CSUM ? DATA_WIDTH'(csum) : '0;
        xfer = m_valid && m_ready;
        pop = xfer && state == PAYLOAD;
        // count the word leaving this cycle so steady state sustains one read per cycle
        fifo_rd_en = state == PAYLOAD && issued < frame_len && !fifo_empty &&
                     ({1'b0, skid_cnt} + {2'b0, inflight} - {2'b0, pop}) < 3'd2;
        flush_pulse = time_go;
        busy = state != IDLE;
        state_nx = state;
        unique case (state)
            IDLE:    state_nx = start ? HDR : IDLE;
            HDR:     state_nx = xfer ? LEN : HDR;
            LEN:     state_nx = xfer ? PAYLOAD : LEN;
            PAYLOAD: state_nx = pop && sent == frame_len - CNT_WIDTH'(1) ? CSUM : PAYLOAD;
            CSUM:    state_nx = xfer ? IDLE : CSUM;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state <= IDLE;
            inflight <= 1'b0;
            timer <= '0;
            frame_len <= '0;
            issued <= '0;
            sent <= '0;
            csum <= '0;
            frame_seq <= '0;
            frames_sent <= '0;
        end else begin
            state <= state_nx;
            inflight <= fifo_rd_en;
            timer <= idle_arm && !time_go ? timer + TW'(1) : '0;
            if (start) begin
                frame_len <= burst_go ? BURST : fifo_count;
                issued <= '0;
                sent <= '0;
                csum <= '0;
            end else begin
                if (xfer && state != CSUM) csum <= csum_add(csum, 16'(m_data));
                if (fifo_rd_en) issued <= issued + CNT_WIDTH'(1);
                if (pop) sent <= sent + CNT_WIDTH'(1);
            end
            if (xfer && state == CSUM) begin
                frame_seq <= frame_seq + 8'd1;
                frames_sent <= frames_sent + 16'd1;
            end
        end
endmodule

// File: tb/tb_fifo_frame_packer.sv
// tb_fifo_frame_packer: random FIFO contents and backpressure against a frame-list reference model.
module tb_fifo_frame_packer;
    localparam int BL = 8;
    localparam int TO = 16;
    localparam int NORM = 0, RAMP = 1, UNDER = 2, RSTM = 3;

    typedef struct packed {logic pay; logic last; logic [15:0] data;} wd_t;

    logic clk, rst, enable, fifo_rd_en, fifo_empty, m_valid, m_ready, m_last, flush_pulse, busy;
    logic [15:0] fifo_rd_data, m_data, frames_sent;
    logic [9:0] fifo_count;
    logic [7:0] frame_seq;

    fifo_frame_packer #(.BURST_LEN(BL), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst(rst), .enable(enable), .fifo_rd_en(fifo_rd_en),
        .fifo_rd_data(fifo_rd_data), .fifo_empty(fifo_empty), .fifo_count(fifo_count),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
        .frame_seq(frame_seq), .frames_sent(frames_sent), .flush_pulse(flush_pulse), .busy(busy)
    );

    int n_cmp = 0, n_bad = 0;
    int rd_cnt = 0, pop_cnt = 0, flush_seen = 0, exp_flush = 0, mframes = 0;
    logic [7:0] mseq = 0;
    logic [15:0] q[$], pend[$], mq[$];
    wd_t exp[$];
    wd_t e;
    logic rd_req = 0, hold_empty = 0, rand_ready = 0, hold_v = 0, pay_now, xf;
    logic [16:0] hold_d;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, want);
        end
    endtask

    initial clk = 0;
    always #5 clk = ~clk;

    initial begin
        m_ready = 1;
        forever begin
            @(posedge clk);
            #1 m_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // FIFO model: registered flags, read data one cycle after the strobe
    initial begin
        fifo_empty = 1;
        fifo_count = 0;
        fifo_rd_data = 0;
    end
    always @(negedge clk) rd_req <= fifo_rd_en;
    always @(posedge clk) begin
        if (rst) begin
            q.delete();
            pend.delete();
        end else begin
            if (rd_req) fifo_rd_data <= q.size() > 0 ? q.pop_front() : 16'hDEAD;
            while (pend.size() > 0) q.push_back(pend.pop_front());
        end
        fifo_count <= q.size() > 1023 ? 10'd1023 : 10'(q.size());
        fifo_empty <= q.size() == 0 || hold_empty;
    end

    always @(negedge clk) begin
        if (rst) begin
            rd_cnt = 0;
            pop_cnt = 0;
            flush_seen = 0;
            hold_v = 0;
        end else begin
            if (hold_v) check("hold", {m_valid, m_last, m_data}, {1'b1, hold_d});
            xf = m_valid && m_ready;
            pay_now = xf && exp.size() > 0 && exp[0].pay;
            if (fifo_rd_en) begin
                check("outstanding", (rd_cnt + 1 - pop_cnt - int'(pay_now)) <= 2, 1);
                rd_cnt++;
            end
            if (xf) begin
                if (exp.size() == 0) check("extra_word", exp.size(), 1);
                else begin
                    e = exp.pop_front();
                    check("word", {m_last, m_data}, {e.last, e.data});
                    if (e.pay) pop_cnt++;
                end
            end
            if (flush_pulse) flush_seen++;
            hold_v = m_valid && !m_ready;
            hold_d = {m_last, m_data};
        end
    end

    // Expected frames straight from the rules: bursts of BL words, then one timeout remainder
    task automatic build();
        int len;
        logic [15:0] sum, w;
        while (mq.size() > 0) begin
            len = mq.size() >= BL ? BL : mq.size();
            if (len < BL) exp_flush++;
            sum = {8'hA5, mseq} + 16'(len);
            exp.push_back('{1'b0, 1'b0, {8'hA5, mseq}});
            exp.push_back('{1'b0, 1'b0, 16'(len)});
            for (int i = 0; i < len; i++) begin
                w = mq.pop_front();
                sum += w;
                exp.push_back('{1'b1, 1'b0, w});
            end
            exp.push_back('{1'b0, 1'b1, sum});
            mseq++;
            mframes++;
        end
    endtask

    task automatic run_batch(input int n, input int mode);
        int cyc, base, hold_t;
        logic got_flush, held, done;
        logic [15:0] w;
        enable = 0;
        for (int i = 0; i < n; i++) begin
            w = mode == RAMP ? 16'(i) : 16'($urandom);
            mq.push_back(w);
            pend.push_back(w);
        end
        cyc = 0;
        while (fifo_count != 10'(n) && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        if (cyc >= 50) check("fill_wait", cyc, 0);
        repeat (3) @(negedge clk);
        check("idle_busy", {busy, m_valid, fifo_rd_en}, 0);
        build();
        base = pop_cnt;
        enable = 1;
        cyc = 0;
        hold_t = 0;
        got_flush = 0;
        held = 0;
        done = 0;
        while (!done && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            if (n < BL && !got_flush && flush_pulse) begin
                check("flush_delay", cyc, TO - 1);
                got_flush = 1;
            end
            if (mode == UNDER && !held && pop_cnt - base >= 4) begin
                hold_empty = 1;
                hold_t = cyc;
                held = 1;
            end
            if (held && hold_empty && cyc - hold_t >= 20) hold_empty = 0;
            if (mode == RSTM && pop_cnt - base >= 3) begin
                rst = 1;
                #1 check("reset_mid", {m_valid, m_last, busy, fifo_rd_en, flush_pulse, frame_seq, frames_sent, m_data}, 0);
                repeat (2) @(negedge clk);
                exp.delete();
                mq.delete();
                mseq = 0;
                mframes = 0;
                exp_flush = 0;
                hold_empty = 0;
                enable = 0;
                rst = 0;
                return;
            end
            done = exp.size() == 0 && !busy;
        end
        check("drain", done, 1);
        check("frames_sent", frames_sent, 16'(mframes));
        check("frame_seq", frame_seq, mseq);
        check("flushes", flush_seen, exp_flush);
        enable = 0;
    endtask

    initial begin
        rst = 1;
        enable = 0;
        repeat (3) @(negedge clk);
        check("reset", {m_valid, m_last, busy, fifo_rd_en, flush_pulse, frame_seq, frames_sent, m_data}, 0);
        rst = 0;
        run_batch(8, RAMP);
        run_batch(3, NORM);
        rand_ready = 1;
        run_batch(8, NORM);
        run_batch(20, NORM);
        run_batch(5, NORM);
        rand_ready = 0;
        run_batch(8, UNDER);
        run_batch(12, RSTM);
        for (int k = 0; k < 257; k++) run_batch(8, NORM);
        rand_ready = 1;
        run_batch(6, NORM);
        run_batch(11, NORM);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
